// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming blocks: default geometry, derived
// counter widths, the window-generator FSM states and the window index helper.
package cnn_pkg;

    localparam int DEF_KERNEL_SIZE  = 3;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_IMAGE_WIDTH  = 28;
    localparam int DEF_IMAGE_HEIGHT = 28;

    localparam int COL_W = $clog2(DEF_IMAGE_WIDTH);
    localparam int ROW_W = $clog2(DEF_IMAGE_HEIGHT);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } win_state_e;

    // Flat position of window element (r, c); must match the convolution engine.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                        input int unsigned k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of storage, addressed by column. The read returns the value
// stored before this cycle's write (read-before-write at a shared address).
module line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 28,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents are never cleared: rows are only consumed after being rewritten.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/window_generator.sv
// Raster-stream to KxK sliding-window producer (stride 1, no padding).
// Optional frame_done output is enabled by defining WINDOW_FRAME_DONE_EN.
module window_generator
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [DATA_WIDTH-1:0]                         pixel_in,
    input  logic                                          pixel_valid,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window,
    output logic                                          window_valid
`ifdef WINDOW_FRAME_DONE_EN
    ,
    output logic                                          frame_done
`endif
);

    localparam int K  = KERNEL_SIZE;
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    win_state_e            state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  last_col, last_row;
    logic                  lb_wr_en;

    logic [DATA_WIDTH-1:0] win_q  [K][K];
    logic [DATA_WIDTH-1:0] lb_rd  [K-1];
    logic [DATA_WIDTH-1:0] new_col[K];

    assign last_col = (col_q == CW'(IMAGE_WIDTH - 1));
    assign last_row = (row_q == RW'(IMAGE_HEIGHT - 1));
    assign lb_wr_en = pixel_valid && !reset;

`ifdef WINDOW_FRAME_DONE_EN
    logic done_q, done_d;
`endif

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        valid_d = 1'b0;
`ifdef WINDOW_FRAME_DONE_EN
        done_d  = 1'b0;
`endif
        if (pixel_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            case (state_q)
                FILL: begin
                    if (last_col && row_q == RW'(K - 2)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Leading K-1 columns would mix in the previous row's tail.
                    valid_d = (col_q >= CW'(K - 1));
                    if (last_col && last_row) begin
                        state_d = FILL;
`ifdef WINDOW_FRAME_DONE_EN
                        done_d  = 1'b1;
`endif
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
`ifdef WINDOW_FRAME_DONE_EN
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
`ifdef WINDOW_FRAME_DONE_EN
            done_q  <= done_d;
`endif
        end
    end

    // Line buffers chained newest (K-2) to oldest (0); each passes its old row down.
    genvar gi, gj;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            logic [DATA_WIDTH-1:0] wr_data;
            if (gi == K - 2) begin : g_newest
                assign wr_data = pixel_in;
            end else begin : g_older
                assign wr_data = lb_rd[gi+1];
            end

            line_buffer #(
                .DATA_WIDTH(DATA_WIDTH),
                .DEPTH     (IMAGE_WIDTH),
                .ADDR_W    (CW)
            ) u_line_buffer (
                .clock    (clock),
                .wr_en_i  (lb_wr_en),
                .addr_i   (col_q),
                .wr_data_i(wr_data),
                .rd_data_o(lb_rd[gi])
            );

            assign new_col[gi] = lb_rd[gi];
        end
        assign new_col[K-1] = pixel_in;

        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_col
                localparam int L = idx(gi, gj, K);

                always_ff @(posedge clock) begin
                    if (reset) begin
                        win_q[gi][gj] <= '0;
                    end else if (pixel_valid) begin
                        if (gj == K - 1) begin
                            win_q[gi][gj] <= new_col[gi];
                        end else begin
                            win_q[gi][gj] <= win_q[gi][(gj == K - 1) ? gj : gj + 1];
                        end
                    end
                end

                assign window[DATA_WIDTH*L +: DATA_WIDTH] = win_q[gi][gj];
            end
        end
    endgenerate

    assign window_valid = valid_q;
`ifdef WINDOW_FRAME_DONE_EN
    assign frame_done = done_q;
`endif

endmodule

// File: doc/window_generator.md
Name: window_generator

Overview:
- Streaming sliding-window producer that feeds the pipelined convolution engine.
- Accepts a raster-order pixel stream, one pixel per valid cycle, and emits KERNEL_SIZE x KERNEL_SIZE windows.
- Window packing is bit-compatible with the convolution engine's data bus, so `window`/`window_valid` connect directly to its `data`/`valid` inputs.
- Stride 1, no padding ("valid" convolution): (IMAGE_HEIGHT-K+1)*(IMAGE_WIDTH-K+1) windows per frame.

Parameters:
- KERNEL_SIZE, 3, window side K (>=2)
- DATA_WIDTH, 16, bits per pixel (fixed-point, opaque to this block)
- IMAGE_WIDTH, 28, pixels per row (>=K)
- IMAGE_HEIGHT, 28, rows per frame (>=K)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- pixel_in  input  DATA_WIDTH  current pixel
- pixel_valid  input  1  pixel_in accepted this cycle; no backpressure
- window  output  DATA_WIDTH*K*K  packed window
- window_valid  output  1  one-cycle pulse per complete window
- frame_done  output  1  present only with WINDOW_FRAME_DONE_EN

Behaviour:
- Clock/reset (already decided): one clock, named `clock`; reset is synchronous and active-high, named `reset`.
- Reset values: window_valid=0, frame_done=0, col=0, row=0, state=FILL, window register=0.
- Line buffer contents are not cleared on reset; they are don't-care because the row gating ignores them.
- Storage:
  - K-1 circular line buffers, each IMAGE_WIDTH deep, indexed by col.
  - A KxK register array; each accepted pixel shifts every row left by one column.
  - The new column is {line buffers oldest..newest, pixel_in}; row 0 is the top (oldest).
- Packing: element l = r*K + c occupies window[DW*(l+1)-1 : DW*l], with r=0 top row and c=0 leftmost column.
- Counters:
  - col runs 0..IMAGE_WIDTH-1 and row runs 0..IMAGE_HEIGHT-1.
  - Both advance only on pixel_valid.
  - col wraps to 0 and increments row; row wraps to 0 after (H-1, W-1).
- FSM:
  - FILL: row < K-1. Pixels are written to the line buffers and no window is emitted. Transition to RUN when the accepted pixel is (K-2, W-1).
  - RUN: window_valid=1 in the cycle after accepting pixel (row, col) with col >= K-1.
  - Transition back to FILL after accepting pixel (H-1, W-1).
- Latency: 1 cycle from pixel accept to window_valid.
- window holds its last value when there is no valid; it changes only on accepted pixels.
- Gaps: pixel_valid=0 stalls all state; back-to-back valids sustain one window per cycle.
- Rows are not wrapped across: the columns col < K-1 of each row produce no window, even though the shift register holds stale previous-row columns.
- Frame boundary: the next frame's first pixel may arrive in the cycle immediately after the last pixel; the FILL restart needs no idle cycle.
- Reset mid-frame: counters and FSM return to initial state; any in-flight window_valid is dropped the cycle after reset.
- reset has priority over a simultaneous pixel_valid.

Optional Feature:
- Macro: WINDOW_FRAME_DONE_EN.
- Defined: frame_done output exists. It pulses high for one cycle, coincident with the window_valid of the final window of the frame, i.e. the window from pixel (H-1, W-1).
- Undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- Shared package cnn_pkg holds:
  - width constants derived via $clog2 (COL_W, ROW_W);
  - the FSM state typedef {FILL, RUN};
  - a window-index function idx(r, c) = r*K + c, shared with the convolution engine.
- One sub-module, line_buffer: a DATA_WIDTH x IMAGE_WIDTH circular buffer with write-enable and a same-cycle read of the old value at the shared col address (read-before-write).

Test Plan:
- K=3, W=H=5, pixels 0..24 back-to-back:
  - first window_valid one cycle after pixel 12, window elements l0..l8 = 0,1,2,5,6,7,10,11,12;
  - 9 windows total;
  - last window = 12,13,14,17,18,19,22,23,24.
- Same stream with pixel_valid toggled 1/0 every cycle -> identical window sequence, each valid one cycle after the accepting edge.
- Two frames back-to-back with no gap -> 18 windows; the second frame's first window again = 0,1,2,5,6,7,10,11,12 (values +25 if the second frame uses 25..49).
- Reset asserted after pixel 13 (row 2, col 3), then restart at 0 -> no window_valid until pixel 12 of the new stream; no residue from the old frame.
- With WINDOW_FRAME_DONE_EN: frame_done high exactly once per frame, same cycle as the window_valid for pixel 24.
- Columns 0..1 of rows 2..4 -> window_valid stays 0, so no cross-row windows.
